// File: rtl/tile_pkg.sv
// Shared types and constants for the tile spawner: FSM states, xorshift32 shift
// amounts, default seed and the one-step PRNG update.
package tile_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DRAW = 2'd1,
    ST_SCAN = 2'd2
  } state_e;

  localparam int unsigned XS_SHL_A = 13;
  localparam int unsigned XS_SHR_B = 17;
  localparam int unsigned XS_SHL_C = 5;

  localparam logic [31:0] DEFAULT_SEED = 32'h392a4953;

  function automatic logic [31:0] xs32_step(input logic [31:0] x);
    logic [31:0] y;
    y = x ^ (x << XS_SHL_A);
    y = y ^ (y >> XS_SHR_B);
    y = y ^ (y << XS_SHL_C);
    return y;
  endfunction

endpackage

// File: rtl/prng_xorshift32.sv
// Free-running xorshift32 generator. Steps every cycle out of reset; a load
// overrides the step, and a zero load value falls back to SEED so the state never sticks at 0.
module prng_xorshift32
  import tile_pkg::*;
#(
  parameter logic [31:0] SEED = DEFAULT_SEED
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic [31:0] state
);

  logic [31:0] state_q, state_d;

  always_comb begin
    state_d = xs32_step(state_q);
    if (load) state_d = (load_val == 32'h0) ? SEED : load_val;
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= SEED;
    else     state_q <= state_d;
  end

  assign state = state_q;

endmodule

// File: rtl/tile_spawner.sv
// Picks an empty board cell for a new tile: up to MAX_TRIES random draws, then a
// linear scan. Optional reseed port enabled by TILE_SPAWNER_SEED_LOAD_EN.
module tile_spawner
  import tile_pkg::*;
#(
  parameter int          CELLS       = 16,
  parameter int          IDX_W       = 4,
  parameter int          MAX_TRIES   = 8,
  parameter logic [31:0] SEED        = DEFAULT_SEED,
  parameter int          FOUR_THRESH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CELLS-1:0] occupied,
`ifdef TILE_SPAWNER_SEED_LOAD_EN
  input  logic             seed_load,
  input  logic [31:0]      seed_in,
`endif
  output logic             busy,
  output logic             done,
  output logic             full,
  output logic [IDX_W-1:0] idx,
  output logic             is_four
);

  localparam int TRY_W = 8;

  state_e           state_q, state_d;
  logic [CELLS-1:0] snap_q, snap_d;
  logic [TRY_W-1:0] try_q, try_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;
  logic             full_q, full_d;
  logic             four_q, four_d;

  logic [31:0]      prng;
  logic             prng_load;
  logic [31:0]      prng_load_val;
  logic [IDX_W-1:0] cand;
  logic             four_now;
  logic             prng_unused;

`ifdef TILE_SPAWNER_SEED_LOAD_EN
  assign prng_load     = seed_load && (state_q == ST_IDLE);
  assign prng_load_val = seed_in;
`else
  assign prng_load     = 1'b0;
  assign prng_load_val = 32'h0;
`endif

  prng_xorshift32 #(.SEED(SEED)) u_prng (
    .clk      (clk),
    .rst      (rst),
    .load     (prng_load),
    .load_val (prng_load_val),
    .state    (prng)
  );

  assign cand        = prng[IDX_W-1:0];
  assign four_now    = {1'b0, prng[31:28]} < 5'(FOUR_THRESH);
  assign prng_unused = ^prng[27:IDX_W];

  // Indices at or beyond CELLS (non power-of-two boards) read as occupied.
  function automatic logic is_free(input logic [CELLS-1:0] s, input logic [IDX_W-1:0] c);
    logic f;
    f = 1'b0;
    for (int i = 0; i < CELLS; i++)
      if (c == IDX_W'(i)) f = ~s[i];
    return f;
  endfunction

  always_comb begin
    state_d = state_q;
    snap_d  = snap_q;
    try_d   = try_q;
    ptr_d   = ptr_q;
    idx_d   = idx_q;
    four_d  = four_q;
    full_d  = full_q;
    done_d  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_DRAW;
          snap_d  = occupied;
          try_d   = '0;
          ptr_d   = '0;
        end
      end
      ST_DRAW: begin
        if (is_free(snap_q, cand)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          full_d  = 1'b0;
          idx_d   = cand;
          four_d  = four_now;
        end else if (try_q == TRY_W'(MAX_TRIES - 1)) begin
          state_d = ST_SCAN;
        end else begin
          try_d = try_q + TRY_W'(1);
        end
      end
      ST_SCAN: begin
        if (is_free(snap_q, ptr_q)) begin
          state_d = ST_IDLE;
          done_d  = 1'b1;
          full_d  = 1'b0;
          idx_d   = ptr_q;
          four_d  = four_now;
        end else if (ptr_q == IDX_W'(CELLS - 1)) begin
          // Board full: idx/is_four keep the previous result.
          state_d = ST_IDLE;
          done_d  = 1'b1;
          full_d  = 1'b1;
        end else begin
          ptr_d = ptr_q + IDX_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      snap_q  <= '0;
      try_q   <= '0;
      ptr_q   <= '0;
      idx_q   <= '0;
      done_q  <= 1'b0;
      full_q  <= 1'b0;
      four_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      snap_q  <= snap_d;
      try_q   <= try_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      done_q  <= done_d;
      full_q  <= full_d;
      four_q  <= four_d;
    end
  end

  assign busy    = (state_q != ST_IDLE);
  assign done    = done_q;
  assign full    = full_q;
  assign idx     = idx_q;
  assign is_four = four_q;

endmodule

// File: tb/tb_tile_spawner.sv
// Self-checking bench for tile_spawner: 16-cell and 9-cell instances against a
// request-level model of the draw/scan rules.
module tb_tile_spawner;

  localparam int          MAX_TRIES   = 8;
  localparam int          FOUR_THRESH = 2;
  localparam logic [31:0] SEED        = 32'h392a4953;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        start0, start1;
  logic [15:0] occ0;
  logic [8:0]  occ1;
  logic        busy0, done0, full0, four0;
  logic        busy1, done1, full1, four1;
  logic [3:0]  idx0, idx1;

  int          ntests = 0;
  int          nfail  = 0;
  logic [31:0] mprng;
  int          last_idx[2];
  logic        last_four[2];

  tile_spawner #(.CELLS(16), .IDX_W(4), .MAX_TRIES(MAX_TRIES), .SEED(SEED),
                 .FOUR_THRESH(FOUR_THRESH)) u_dut16 (
    .clk(clk), .rst(rst), .start(start0), .occupied(occ0),
`ifdef TILE_SPAWNER_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(32'h0),
`endif
    .busy(busy0), .done(done0), .full(full0), .idx(idx0), .is_four(four0)
  );

  tile_spawner #(.CELLS(9), .IDX_W(4), .MAX_TRIES(MAX_TRIES), .SEED(SEED),
                 .FOUR_THRESH(FOUR_THRESH)) u_dut9 (
    .clk(clk), .rst(rst), .start(start1), .occupied(occ1),
`ifdef TILE_SPAWNER_SEED_LOAD_EN
    .seed_load(1'b0), .seed_in(32'h0),
`endif
    .busy(busy1), .done(done1), .full(full1), .idx(idx1), .is_four(four1)
  );

  function automatic logic [31:0] xs(input logic [31:0] x);
    x = x ^ (x << 13);
    x = x ^ (x >> 17);
    x = x ^ (x << 5);
    return x;
  endfunction

  // PRNG value seen by the DUT in each cycle
  always @(posedge clk) mprng <= rst ? SEED : xs(mprng);

  // Request outcome given the PRNG value of the first DRAW cycle.
  function automatic void model(input logic [31:0] p0, input logic [63:0] occ, input int cells,
                                output int eidx, output logic efour, output logic efull,
                                output int elat);
    logic [31:0] p;
    int c;
    p = p0;
    for (int t = 0; t < MAX_TRIES; t++) begin
      c = int'(p[3:0]);
      if (c < cells && !occ[c]) begin
        eidx = c; efour = (int'(p[31:28]) < FOUR_THRESH); efull = 1'b0; elat = t + 2;
        return;
      end
      p = xs(p);
    end
    for (int k = 0; k < cells; k++) begin
      if (!occ[k]) begin
        eidx = k; efour = (int'(p[31:28]) < FOUR_THRESH); efull = 1'b0; elat = MAX_TRIES + k + 2;
        return;
      end
      p = xs(p);
    end
    eidx = 0; efour = 1'b0; efull = 1'b1; elat = 1 + MAX_TRIES + cells;
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    ntests++;
    assert (got === exp) else begin
      nfail++;
      $error("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic get(input int sel, output logic b, output logic d, output logic f,
                     output logic [3:0] i, output logic fr);
    if (sel != 0) begin b = busy1; d = done1; f = full1; i = idx1; fr = four1; end
    else          begin b = busy0; d = done0; f = full0; i = idx0; fr = four0; end
  endtask

  task automatic do_req(input int sel, input logic [15:0] occ, input logic hold,
                        input logic scramble, output logic got_four);
    logic [31:0] p;
    int          eidx, elat, cells, lat;
    logic        efour, efull, b, d, f, fr;
    logic [3:0]  i;
    cells = (sel != 0) ? 9 : 16;
    if (sel != 0) begin occ1 = occ[8:0]; start1 = 1'b1; end
    else          begin occ0 = occ;      start0 = 1'b1; end
    tick();
    p = mprng;
    model(p, 64'(occ), cells, eidx, efour, efull, elat);
    if (!hold) begin start0 = 1'b0; start1 = 1'b0; end
    if (scramble) begin occ0 = 16'($urandom); occ1 = 9'($urandom); end
    lat = 1;
    get(sel, b, d, f, i, fr);
    while (!d && lat < 1 + MAX_TRIES + cells + 4) begin
      check("busy_inflight", 32'(b), 1);
      tick();
      lat++;
      get(sel, b, d, f, i, fr);
    end
    start0 = 1'b0; start1 = 1'b0;
    check("done_seen", 32'(d), 1);
    check("latency", lat, elat);
    check("busy_with_done", 32'(b), 0);
    check("full", 32'(f), 32'(efull));
    if (efull) begin
      check("idx_hold", 32'(i), last_idx[sel]);
      check("four_hold", 32'(fr), 32'(last_four[sel]));
    end else begin
      check("idx", 32'(i), eidx);
      check("is_four", 32'(fr), 32'(efour));
      last_idx[sel] = eidx; last_four[sel] = efour;
    end
    got_four = fr;
    tick();
    get(sel, b, d, f, i, fr);
    check("no_extra_done", 32'(d), 0);
    check("idle_after", 32'(b), 0);
  endtask

  initial begin
    logic        b, d, f, fr, gf;
    logic [3:0]  i;
    logic [31:0] s1;
    logic [15:0] occ;
    int          nfour;

    rst = 1'b1; start0 = 1'b0; start1 = 1'b0; occ0 = '0; occ1 = '0;
    last_idx[0] = 0; last_idx[1] = 0; last_four[0] = 1'b0; last_four[1] = 1'b0;
    tick(); tick();
    check("rst_busy", 32'(busy0), 0);
    check("rst_done", 32'(done0), 0);
    check("rst_full", 32'(full0), 0);
    check("rst_idx", 32'(idx0), 0);
    check("rst_four", 32'(four0), 0);
    check("rst_busy9", 32'(busy1), 0);
    check("rst_done9", 32'(done1), 0);

    // Empty board straight out of reset: first draw hits
    rst = 1'b0;
    do_req(0, 16'h0000, 1'b0, 1'b0, gf);
    s1 = xs(SEED);
    check("first_idx", 32'(idx0), 32'(s1[3:0]));

    do_req(0, 16'hFFDF, 1'b0, 1'b1, gf);
    check("only_free_5", 32'(idx0), 5);

    do_req(0, 16'hFFFF, 1'b1, 1'b0, gf);

    // Reset while scanning a full board
    occ0 = 16'hFFFF; start0 = 1'b1;
    tick();
    start0 = 1'b0;
    for (int k = 1; k < 14; k++) begin
      check("pre_rst_no_done", 32'(done0), 0);
      check("pre_rst_busy", 32'(busy0), 1);
      tick();
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_busy", 32'(busy0), 0);
    check("midrst_done", 32'(done0), 0);
    check("midrst_full", 32'(full0), 0);
    check("midrst_idx", 32'(idx0), 0);
    check("midrst_four", 32'(four0), 0);
    last_idx[0] = 0; last_idx[1] = 0; last_four[0] = 1'b0; last_four[1] = 1'b0;
    do_req(0, 16'h0F0F, 1'b0, 1'b1, gf);

    // 9-cell board, only cell 0 free
    for (int k = 0; k < 5; k++) begin
      do_req(1, 16'h01FE, k[0], 1'b1, gf);
      check("c9_idx0", 32'(idx1), 0);
    end
    do_req(1, 16'h01FF, 1'b0, 1'b0, gf);

    // Randomized occupancy on both boards
    for (int k = 0; k < 400; k++) begin
      case ($urandom_range(0, 3))
        0: occ = 16'($urandom);
        1: occ = 16'($urandom & $urandom);
        2: occ = 16'($urandom | $urandom | $urandom);
        default: occ = ~(16'h1 << $urandom_range(0, 15));
      endcase
      do_req(k % 3 == 0 ? 1 : 0, occ, 1'($urandom), 1'($urandom), gf);
    end

    // Tile-value distribution on an empty board
    nfour = 0;
    for (int k = 0; k < 10000; k++) begin
      do_req(0, 16'h0000, 1'($urandom), 1'($urandom), gf);
      if (gf) nfour++;
    end
    check("four_rate_in_band", 32'(nfour >= 1100 && nfour <= 1400), 1);

    get(0, b, d, f, i, fr);
    check("final_idle", 32'(b), 0);

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
